// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with stall, flush-to-NOP, invalid-slot
// squashing and a saturating bubble counter.
module decode_execute_register #(
    parameter int unsigned N = 32,
    parameter int unsigned V = 128,
    parameter int unsigned R = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         StallE,
    input  logic         FlushE,
    input  logic         ValidD,
    input  logic         RegWriteD,
    input  logic         RegWriteVD,
    input  logic         MemtoRegD,
    input  logic         MemWriteD,
    input  logic         MemSrcD,
    input  logic         MemDataD,
    input  logic         MemDataVD,
    input  logic         VecDataD,
    input  logic         BranchD,
    input  logic         ALUSrcD,
    input  logic [1:0]   InstrSelD,
    input  logic [2:0]   ALUControlD,
    input  logic [N-1:0] RD1D,
    input  logic [N-1:0] RD2D,
    input  logic [V-1:0] RD1VD,
    input  logic [V-1:0] RD2VD,
    input  logic [N-1:0] ExtImmD,
    input  logic [R-1:0] Rs1D,
    input  logic [R-1:0] Rs2D,
    input  logic [R-1:0] RdD,
    output logic         ValidE,
    output logic         RegWriteE,
    output logic         RegWriteVE,
    output logic         MemtoRegE,
    output logic         MemWriteE,
    output logic         MemSrcE,
    output logic         MemDataE,
    output logic         MemDataVE,
    output logic         VecDataE,
    output logic         BranchE,
    output logic         ALUSrcE,
    output logic [1:0]   InstrSelE,
    output logic [2:0]   ALUControlE,
    output logic [N-1:0] RD1E,
    output logic [N-1:0] RD2E,
    output logic [V-1:0] RD1VE,
    output logic [V-1:0] RD2VE,
    output logic [N-1:0] ExtImmE,
    output logic [R-1:0] Rs1E,
    output logic [R-1:0] Rs2E,
    output logic [R-1:0] RdE,
    output logic [7:0]   BubbleCountE
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // A bubble enters execute on a flush, or on a normal load of an empty slot.
    logic bubble_c;
    assign bubble_c = FlushE | (~StallE & ~ValidD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            RegWriteVE  <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            MemSrcE     <= 1'b0;
            MemDataE    <= 1'b0;
            MemDataVE   <= 1'b0;
            VecDataE    <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            InstrSelE   <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            RD1VE       <= '0;
            RD2VE       <= '0;
            ExtImmE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else if (FlushE) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            RegWriteVE  <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            MemSrcE     <= 1'b0;
            MemDataE    <= 1'b0;
            MemDataVE   <= 1'b0;
            VecDataE    <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            InstrSelE   <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            RD1VE       <= '0;
            RD2VE       <= '0;
            ExtImmE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else if (!StallE) begin
            // Empty slots keep their data but lose every architectural side effect.
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD & ValidD;
            RegWriteVE  <= RegWriteVD & ValidD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD & ValidD;
            MemSrcE     <= MemSrcD;
            MemDataE    <= MemDataD;
            MemDataVE   <= MemDataVD;
            VecDataE    <= VecDataD;
            BranchE     <= BranchD & ValidD;
            ALUSrcE     <= ALUSrcD;
            InstrSelE   <= InstrSelD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            RD1VE       <= RD1VD;
            RD2VE       <= RD2VD;
            ExtImmE     <= ExtImmD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCountE <= '0;
        end else if (bubble_c && (BubbleCountE != CNT_MAX)) begin
            BubbleCountE <= BubbleCountE + CW'(1);
        end
    end

endmodule

// File: tb/tb_decode_execute_register.sv
// Randomized and directed checks of decode_execute_register against a
// transaction-level model of the pipeline slot and bubble tally.
module tb_decode_execute_register;

    typedef struct packed {
        logic         valid;
        logic         regwrite;
        logic         regwritev;
        logic         memtoreg;
        logic         memwrite;
        logic         memsrc;
        logic         memdata;
        logic         memdatav;
        logic         vecdata;
        logic         branch;
        logic         alusrc;
        logic [1:0]   instrsel;
        logic [2:0]   aluctrl;
        logic [31:0]  rd1;
        logic [31:0]  rd2;
        logic [127:0] rd1v;
        logic [127:0] rd2v;
        logic [31:0]  imm;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
    } slot_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   stall;
    logic   flush;
    slot_t  d;
    slot_t  e;
    logic [7:0] bcnt;

    slot_t  exp_e;
    int     exp_cnt;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    decode_execute_register dut (
        .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush),
        .ValidD(d.valid), .RegWriteD(d.regwrite), .RegWriteVD(d.regwritev),
        .MemtoRegD(d.memtoreg), .MemWriteD(d.memwrite), .MemSrcD(d.memsrc),
        .MemDataD(d.memdata), .MemDataVD(d.memdatav), .VecDataD(d.vecdata),
        .BranchD(d.branch), .ALUSrcD(d.alusrc), .InstrSelD(d.instrsel),
        .ALUControlD(d.aluctrl), .RD1D(d.rd1), .RD2D(d.rd2),
        .RD1VD(d.rd1v), .RD2VD(d.rd2v), .ExtImmD(d.imm),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
        .ValidE(e.valid), .RegWriteE(e.regwrite), .RegWriteVE(e.regwritev),
        .MemtoRegE(e.memtoreg), .MemWriteE(e.memwrite), .MemSrcE(e.memsrc),
        .MemDataE(e.memdata), .MemDataVE(e.memdatav), .VecDataE(e.vecdata),
        .BranchE(e.branch), .ALUSrcE(e.alusrc), .InstrSelE(e.instrsel),
        .ALUControlE(e.aluctrl), .RD1E(e.rd1), .RD2E(e.rd2),
        .RD1VE(e.rd1v), .RD2VE(e.rd2v), .ExtImmE(e.imm),
        .Rs1E(e.rs1), .Rs2E(e.rs2), .RdE(e.rd),
        .BubbleCountE(bcnt)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: what the execute slot should hold after one edge, in plain terms.
    task automatic model_edge();
        if (!rst_n) return;
        if (flush) begin
            exp_e = '0;
            exp_cnt = exp_cnt + 1;
        end else if (!stall) begin
            exp_e = d;
            if (!d.valid) begin
                exp_e.regwrite  = 1'b0;
                exp_e.regwritev = 1'b0;
                exp_e.memwrite  = 1'b0;
                exp_e.branch    = 1'b0;
                exp_cnt = exp_cnt + 1;
            end
        end
        if (exp_cnt > 255) exp_cnt = 255;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_slot"}, 512'(e), 512'(exp_e));
        check({tag, "_bcnt"}, 512'(bcnt), 512'(exp_cnt));
    endtask

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid     = ($urandom_range(0, 3) != 0);
        s.regwrite  = 1'($urandom);
        s.regwritev = 1'($urandom);
        s.memtoreg  = 1'($urandom);
        s.memwrite  = 1'($urandom);
        s.memsrc    = 1'($urandom);
        s.memdata   = 1'($urandom);
        s.memdatav  = 1'($urandom);
        s.vecdata   = 1'($urandom);
        s.branch    = 1'($urandom);
        s.alusrc    = 1'($urandom);
        s.instrsel  = 2'($urandom);
        s.aluctrl   = 3'($urandom);
        s.rd1       = $urandom;
        s.rd2       = $urandom;
        s.rd1v      = {$urandom, $urandom, $urandom, $urandom};
        s.rd2v      = {$urandom, $urandom, $urandom, $urandom};
        s.imm       = $urandom;
        s.rs1       = 5'($urandom);
        s.rs2       = 5'($urandom);
        s.rd        = 5'($urandom);
        return s;
    endfunction

    function automatic slot_t ref_load();
        slot_t s = '0;
        s.valid    = 1'b1;
        s.regwrite = 1'b1;
        s.aluctrl  = 3'b101;
        s.rd1      = 32'hDEADBEEF;
        s.rd1v     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        s.rd       = 5'd7;
        return s;
    endfunction

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        d = rand_slot();
        exp_e = '0;
        exp_cnt = 0;

        // Edges under reset must have no effect.
        repeat (2) tick();
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed load
        d = ref_load();
        tick();
        check_all("load");
        check("load_rd1", 512'(e.rd1), 512'(32'hDEADBEEF));
        check("load_rd1v", 512'(e.rd1v), 512'(128'h00112233_44556677_8899AABB_CCDDEEFF));
        check("load_rd", 512'(e.rd), 512'(5'd7));
        check("load_alu", 512'(e.aluctrl), 512'(3'b101));
        check("load_bcnt0", 512'(bcnt), 512'(0));

        // Stall for three edges with new data presented
        d.rd1 = 32'h12345678;
        stall = 1'b1;
        repeat (3) tick();
        check_all("stall");
        check("stall_rd1", 512'(e.rd1), 512'(32'hDEADBEEF));
        check("stall_rd", 512'(e.rd), 512'(5'd7));

        // Flush wins over stall
        flush = 1'b1;
        tick();
        check_all("flushstall");
        check("flushstall_zero", 512'(e), 512'(0));
        check("flushstall_bcnt", 512'(bcnt), 512'(1));
        stall = 1'b0;
        flush = 1'b0;

        // Invalid load squashes side effects but keeps data
        d = rand_slot();
        d.valid = 1'b0;
        d.regwrite = 1'b1;
        d.memwrite = 1'b1;
        d.branch = 1'b1;
        d.rd2 = 32'hCAFEF00D;
        tick();
        check_all("invalid");
        check("invalid_ctl", 512'({e.regwrite, e.memwrite, e.branch}), 512'(3'b000));
        check("invalid_rd2", 512'(e.rd2), 512'(32'hCAFEF00D));
        check("invalid_bcnt", 512'(bcnt), 512'(2));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            d = rand_slot();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            tick();
            check_all("rand");
        end
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset mid-cycle while stalled with live contents
        d = ref_load();
        tick();
        stall = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_e = '0;
        exp_cnt = 0;
        #1;
        check_all("async_rst");
        stall = 1'b0;
        tick();
        check_all("rst_hold");

        // Saturation from reset
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b1;
        repeat (254) tick();
        check("sat_254", 512'(bcnt), 512'(8'hFE));
        tick();
        check("sat_255", 512'(bcnt), 512'(8'hFF));
        repeat (5) tick();
        check_all("sat_260");
        check("sat_ff", 512'(bcnt), 512'(8'hFF));
        flush = 1'b0;

        // Reset then reload reference values
        @(negedge clk);
        rst_n = 1'b0;
        exp_e = '0;
        exp_cnt = 0;
        #1;
        check_all("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        d = ref_load();
        tick();
        check_all("reload");
        check("reload_rd1", 512'(e.rd1), 512'(32'hDEADBEEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
